apb_requester_bridge: RTL and testbench

//  APB requester (master) driving one APB completer such as the peripheral register bank.

---
 rtl/apb_requester_bridge.sv | 118 +++++++++++
 tb/tb_apb_requester_bridge.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester_bridge.sv
// APB requester: takes one read/write command at a time over valid/ready, runs the
// SETUP/ACCESS phases on the APB bus and returns data/error/timeout status over valid/ready.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel high, penable low, payload driven from the latched command
// ACCESS | psel and penable high, waiting for pready or the wait-state timeout
// RESP   | rsp_valid high, response held until rsp_ready
module apb_requester_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk_periph_100mhz,
    input  logic              rst_periph_domain_n_sync,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] apb_paddr,
    output logic              apb_psel,
    output logic              apb_penable,
    output logic              apb_pwrite,
    output logic [DATA_W-1:0] apb_pwdata,
    input  logic [DATA_W-1:0] apb_prdata,
    input  logic              apb_pready,
    input  logic              apb_pslverr,
    output logic              busy,
    output logic [15:0]       txn_count
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int   TO_LOAD = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int   CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic TO_EN   = (TIMEOUT_CYCLES > 0);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk_periph_100mhz) begin
        if (!rst_periph_domain_n_sync) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            apb_paddr   <= '0;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            apb_pwrite  <= 1'b0;
            apb_pwdata  <= '0;
            busy        <= 1'b0;
            txn_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // The APB payload registers double as the command latch.
                    if (cmd_valid) begin
                        apb_paddr  <= cmd_addr;
                        apb_pwrite <= cmd_write;
                        apb_pwdata <= cmd_wdata;
                        apb_psel   <= 1'b1;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    apb_penable <= 1'b1;
                    wait_cnt    <= CNT_W'(TO_LOAD);
                    state       <= ACCESS;
                end
                ACCESS: begin
                    // pready is checked first so it wins over a timeout in the same cycle.
                    if (apb_pready) begin
                        apb_psel    <= 1'b0;
                        apb_penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= apb_pwrite ? '0 : apb_prdata;
                        rsp_error   <= apb_pslverr;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (TO_EN && wait_cnt == '0) begin
                        apb_psel    <= 1'b0;
                        apb_penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        txn_count <= txn_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_requester_bridge.sv
// Testbench for apb_requester_bridge: directed scenarios with an expected-response queue.
module tb_apb_requester_bridge;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    logic        clk_periph_100mhz = 1'b0;
    logic        rst_periph_domain_n_sync;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] apb_paddr, apb_pwdata, apb_prdata;
    logic        apb_psel, apb_penable, apb_pwrite, apb_pready, apb_pslverr;
    logic        busy;
    logic [15:0] txn_count;

    int   errors = 0;
    int   checks = 0;
    int   exp_count = 0;
    rsp_t exp_q[$];
    rsp_t exp;

    apb_requester_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk_periph_100mhz(clk_periph_100mhz),
        .rst_periph_domain_n_sync(rst_periph_domain_n_sync),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .apb_paddr(apb_paddr), .apb_psel(apb_psel), .apb_penable(apb_penable),
        .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
        .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
        .busy(busy), .txn_count(txn_count)
    );

    always #5 clk_periph_100mhz = ~clk_periph_100mhz;

    // Outputs are sampled and inputs driven at the falling edge.
    task automatic tick();
        @(negedge clk_periph_100mhz);
    endtask

    task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr, input logic eto);
        rsp_t r;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_write = wr;
        cmd_wdata = wd;
        r.rdata = erd;
        r.err   = eerr;
        r.to    = eto;
        exp_q.push_back(r);
    endtask

    task automatic test_reset();
        rst_periph_domain_n_sync = 1'b0;
        tick();
        tick();
        checks++;
        if ({cmd_ready, apb_psel, apb_penable, rsp_valid, busy, rsp_error, rsp_timeout} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 1000000",
                     {cmd_ready, apb_psel, apb_penable, rsp_valid, busy, rsp_error, rsp_timeout});
        end
        checks++;
        if (txn_count !== 16'd0 || apb_paddr !== 32'd0 || rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: count=%0d paddr=%h rdata=%h want 0", txn_count, apb_paddr, rsp_rdata);
        end
        rst_periph_domain_n_sync = 1'b1;
        tick();
    endtask

    task automatic test_write_zero_wait();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_cmd_ready: got %b want 1", cmd_ready);
        end
        issue(32'h04, 1'b1, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
        apb_pready = 1'b1;
        apb_prdata = 32'h7777_7777;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({apb_psel, apb_penable, apb_pwrite, cmd_ready, busy} !== 5'b10101 ||
            apb_paddr !== 32'h04 || apb_pwdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL wr_setup: sel/en/wr/rdy/busy=%b paddr=%h pwdata=%h want 10101 04 a5a5a5a5",
                     {apb_psel, apb_penable, apb_pwrite, cmd_ready, busy}, apb_paddr, apb_pwdata);
        end
        tick();
        checks++;
        if ({apb_psel, apb_penable, rsp_valid} !== 3'b110) begin
            errors++;
            $display("FAIL wr_access: sel/en/rv=%b want 110", {apb_psel, apb_penable, rsp_valid});
        end
        tick();
        checks++;
        if ({apb_psel, apb_penable, rsp_valid} !== 3'b001) begin
            errors++;
            $display("FAIL wr_resp_phase: sel/en/rv=%b want 001", {apb_psel, apb_penable, rsp_valid});
        end
        rsp_ready = 1'b1;
        exp = exp_q.pop_front();
        checks++;
        if (rsp_rdata !== exp.rdata || rsp_error !== exp.err || rsp_timeout !== exp.to) begin
            errors++;
            $display("FAIL wr_rsp: rdata=%h err=%b to=%b want %h %b %b",
                     rsp_rdata, rsp_error, rsp_timeout, exp.rdata, exp.err, exp.to);
        end
        tick();
        rsp_ready = 1'b0;
        exp_count++;
        checks++;
        if (txn_count !== 16'(exp_count) || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: count=%0d rv=%b rdy=%b busy=%b want %0d 0 1 0",
                     txn_count, rsp_valid, cmd_ready, busy, exp_count);
        end
        apb_pready = 1'b0;
    endtask

    task automatic test_read_wait_states();
        int n_access = 0;
        issue(32'h18, 1'b0, 32'h0, 32'h1234, 1'b0, 1'b0);
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;
        apb_pready = 1'b0;
        tick();
        // Final wait cycle coincides with the timeout limit; pready must win.
        for (int k = 0; k < 4; k++) begin
            if (apb_psel && apb_penable) n_access++;
            checks++;
            if (apb_paddr !== 32'h18 || apb_pwrite !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rd_payload_k%0d: paddr=%h pwrite=%b rv=%b want 18 0 0",
                         k, apb_paddr, apb_pwrite, rsp_valid);
            end
            apb_pready = (k == 3);
            apb_prdata = (k == 3) ? 32'h1234 : 32'hBAD0_0000 + 32'(k);
            tick();
        end
        apb_pready = 1'b0;
        checks++;
        if (n_access !== 4 || rsp_valid !== 1'b1 || apb_psel !== 1'b0) begin
            errors++;
            $display("FAIL rd_access_len: access=%0d rv=%b sel=%b want 4 1 0", n_access, rsp_valid, apb_psel);
        end
        rsp_ready = 1'b1;
        exp = exp_q.pop_front();
        checks++;
        if (rsp_rdata !== exp.rdata || rsp_error !== exp.err || rsp_timeout !== exp.to) begin
            errors++;
            $display("FAIL rd_rsp: rdata=%h err=%b to=%b want %h %b %b",
                     rsp_rdata, rsp_error, rsp_timeout, exp.rdata, exp.err, exp.to);
        end
        tick();
        rsp_ready = 1'b0;
        exp_count++;
    endtask

    task automatic test_slverr();
        issue(32'hFC, 1'b0, 32'h0, 32'hDEAD, 1'b1, 1'b0);
        tick();
        cmd_valid   = 1'b0;
        apb_pready  = 1'b1;
        apb_pslverr = 1'b1;
        apb_prdata  = 32'hDEAD;
        tick();
        tick();
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL err_rsp_valid: got %b want 1", rsp_valid);
        end
        rsp_ready = 1'b1;
        exp = exp_q.pop_front();
        checks++;
        if (rsp_rdata !== exp.rdata || rsp_error !== exp.err || rsp_timeout !== exp.to) begin
            errors++;
            $display("FAIL err_rsp: rdata=%h err=%b to=%b want %h %b %b",
                     rsp_rdata, rsp_error, rsp_timeout, exp.rdata, exp.err, exp.to);
        end
        tick();
        rsp_ready = 1'b0;
        exp_count++;
    endtask

    task automatic test_timeout();
        int n_access = 0;
        issue(32'h20, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        tick();
        cmd_valid  = 1'b0;
        apb_pready = 1'b0;
        apb_prdata = 32'hFFFF_FFFF;
        tick();
        while (apb_psel && apb_penable && n_access < 20) begin
            n_access++;
            tick();
        end
        checks++;
        if (n_access !== 4 || rsp_valid !== 1'b1 || apb_psel !== 1'b0) begin
            errors++;
            $display("FAIL to_wait_len: access=%0d rv=%b sel=%b want 4 1 0", n_access, rsp_valid, apb_psel);
        end
        rsp_ready = 1'b1;
        exp = exp_q.pop_front();
        checks++;
        if (rsp_rdata !== exp.rdata || rsp_error !== exp.err || rsp_timeout !== exp.to) begin
            errors++;
            $display("FAIL to_rsp: rdata=%h err=%b to=%b want %h %b %b",
                     rsp_rdata, rsp_error, rsp_timeout, exp.rdata, exp.err, exp.to);
        end
        tick();
        rsp_ready = 1'b0;
        exp_count++;
        checks++;
        if (txn_count !== 16'(exp_count)) begin
            errors++;
            $display("FAIL to_count: got %0d want %0d", txn_count, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        // Write while the completer drives junk prdata: write response must read back 0.
        issue(32'h08, 1'b1, 32'h11, 32'h0, 1'b0, 1'b0);
        apb_pready = 1'b1;
        apb_prdata = 32'h5555;
        tick();
        cmd_addr  = 32'h0C;
        cmd_write = 1'b0;
        cmd_wdata = 32'h99;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || cmd_ready !== 1'b0 ||
                apb_paddr !== 32'h08 || apb_psel !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL b2b_stall: %0d cycles unstable want 0", bad);
        end
        rsp_ready = 1'b1;
        exp = exp_q.pop_front();
        checks++;
        if (rsp_rdata !== exp.rdata || rsp_error !== exp.err || rsp_timeout !== exp.to) begin
            errors++;
            $display("FAIL b2b_rsp1: rdata=%h err=%b to=%b want %h %b %b",
                     rsp_rdata, rsp_error, rsp_timeout, exp.rdata, exp.err, exp.to);
        end
        tick();
        rsp_ready = 1'b0;
        exp_count++;
        checks++;
        if (cmd_ready !== 1'b1 || txn_count !== 16'(exp_count)) begin
            errors++;
            $display("FAIL b2b_reaccept: rdy=%b count=%0d want 1 %0d", cmd_ready, txn_count, exp_count);
        end
        issue(32'h0C, 1'b0, 32'h99, 32'h5555, 1'b0, 1'b0);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (apb_psel !== 1'b1 || apb_penable !== 1'b0 || apb_paddr !== 32'h0C || apb_pwrite !== 1'b0) begin
            errors++;
            $display("FAIL b2b_setup2: sel=%b en=%b paddr=%h wr=%b want 1 0 0c 0",
                     apb_psel, apb_penable, apb_paddr, apb_pwrite);
        end
        tick();
        tick();
        apb_pready = 1'b0;
        rsp_ready  = 1'b1;
        exp = exp_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp.rdata || rsp_error !== exp.err || rsp_timeout !== exp.to) begin
            errors++;
            $display("FAIL b2b_rsp2: rv=%b rdata=%h err=%b to=%b want 1 %h %b %b",
                     rsp_valid, rsp_rdata, rsp_error, rsp_timeout, exp.rdata, exp.err, exp.to);
        end
        tick();
        rsp_ready = 1'b0;
        exp_count++;
    endtask

    task automatic test_reset_mid_transfer();
        issue(32'h30, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        apb_pready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (apb_penable !== 1'b1 || txn_count === 16'd0) begin
            errors++;
            $display("FAIL rst_pre: en=%b count=%0d want 1 nonzero", apb_penable, txn_count);
        end
        rst_periph_domain_n_sync = 1'b0;
        tick();
        rst_periph_domain_n_sync = 1'b1;
        exp_q.delete();
        exp_count = 0;
        checks++;
        if ({apb_psel, apb_penable, rsp_valid, cmd_ready, busy} !== 5'b00010 || txn_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid: sel/en/rv/rdy/busy=%b count=%0d want 00010 0",
                     {apb_psel, apb_penable, rsp_valid, cmd_ready, busy}, txn_count);
        end
        tick();
        tick();
        checks++;
        if (apb_psel !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle_hold: sel=%b rv=%b want 0 0", apb_psel, rsp_valid);
        end
    endtask

    initial begin
        rst_periph_domain_n_sync = 1'b0;
        cmd_valid   = 1'b0;
        cmd_addr    = '0;
        cmd_write   = 1'b0;
        cmd_wdata   = '0;
        rsp_ready   = 1'b0;
        apb_prdata  = '0;
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;
        tick();
        test_reset();
        test_write_zero_wait();
        test_read_wait_states();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid_transfer();
        test_write_zero_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
